// File: rtl/ldpc_layer_scheduler_if.sv
// Layer descriptor channel from the LDPC layer scheduler to the decoder datapath.
// The master presents one compacted base row per valid/ready handshake.
interface ldpc_layer_scheduler_if #(
  parameter int DMAX    = 6,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int SHIFT_W = 6,
  parameter int DEG_W   = 3
);
  logic                    lyr_valid;
  logic                    lyr_ready;
  logic [ROW_W-1:0]        lyr_row;
  logic [DEG_W-1:0]        lyr_deg;
  logic [DMAX*COL_W-1:0]   lyr_col;
  logic [DMAX*SHIFT_W-1:0] lyr_shift;
  logic                    lyr_last;

  modport master (
    output lyr_valid, lyr_row, lyr_deg, lyr_col, lyr_shift, lyr_last,
    input  lyr_ready
  );

  modport slave (
    input  lyr_valid, lyr_row, lyr_deg, lyr_col, lyr_shift, lyr_last,
    output lyr_ready
  );
endinterface

// File: rtl/ldpc_layer_scheduler.sv
// Layered QC-LDPC schedule sequencer: scans the shift table row by row, compacts
// non-null blocks into DMAX slots and emits one descriptor per layer per iteration.
module ldpc_layer_scheduler #(
  parameter int Z        = 32,
  parameter int DMAX     = 6,
  parameter int ROW_CNT  = 10,
  parameter int COL_CNT  = 10,
  parameter int MAX_ITER = 8,
  parameter int SHIFT_W  = $clog2(Z) + 1,
  parameter int COL_W    = $clog2(COL_CNT),
  parameter int ROW_W    = $clog2(ROW_CNT),
  parameter int IT_W     = $clog2(MAX_ITER + 1),
  parameter int DEG_W    = $clog2(DMAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we_i,
  input  logic [ROW_W-1:0]          cfg_row_i,
  input  logic [COL_W-1:0]          cfg_col_i,
  input  logic signed [SHIFT_W-1:0] cfg_shift_i,
  input  logic                      start_i,
  input  logic                      early_stop_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [IT_W-1:0]           iter_cnt_o,
  output logic                      deg_err_o,
  ldpc_layer_scheduler_if.master    lyr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t                    state_q;
  logic [ROW_W-1:0]          row_q;
  logic [COL_W-1:0]          col_q;
  logic [DEG_W-1:0]          deg_q;
  logic [IT_W-1:0]           iter_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      deg_err_q;
  logic                      valid_q;
  logic                      last_q;
  logic [COL_W-1:0]          slot_col_q   [DMAX];
  logic signed [SHIFT_W-1:0] slot_shift_q [DMAX];
  logic signed [SHIFT_W-1:0] table_q      [ROW_CNT][COL_CNT];

  logic signed [SHIFT_W-1:0] scan_shift;
  logic                      scan_hit;
  logic                      cfg_ok;

  assign scan_shift = table_q[row_q][col_q];
  // A negative shift (sign bit set) marks an all-zero block.
  assign scan_hit   = ~scan_shift[SHIFT_W-1];
  assign cfg_ok     = cfg_we_i && (32'(cfg_row_i) < ROW_CNT) && (32'(cfg_col_i) < COL_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      deg_q     <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      deg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      for (int k = 0; k < DMAX; k++) begin
        slot_col_q[k]   <= '0;
        slot_shift_q[k] <= '1;
      end
      for (int r = 0; r < ROW_CNT; r++) begin
        for (int c = 0; c < COL_CNT; c++) begin
          table_q[r][c] <= '1;
        end
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_ok) begin
            table_q[cfg_row_i][cfg_col_i] <= cfg_shift_i;
          end
          if (start_i) begin
            state_q   <= ST_SCAN;
            row_q     <= '0;
            col_q     <= '0;
            deg_q     <= '0;
            iter_q    <= '0;
            deg_err_q <= 1'b0;
            busy_q    <= 1'b1;
            for (int k = 0; k < DMAX; k++) begin
              slot_col_q[k]   <= '0;
              slot_shift_q[k] <= '1;
            end
          end
        end

        ST_SCAN: begin
          if (scan_hit) begin
            if (deg_q < DEG_W'(DMAX)) begin
              slot_col_q[deg_q]   <= col_q;
              slot_shift_q[deg_q] <= scan_shift;
              deg_q               <= deg_q + 1'b1;
            end else begin
              deg_err_q <= 1'b1;
            end
          end
          if (col_q == COL_W'(COL_CNT - 1)) begin
            col_q   <= '0;
            state_q <= ST_EMIT;
            valid_q <= 1'b1;
            last_q  <= (row_q == ROW_W'(ROW_CNT - 1));
          end else begin
            col_q <= col_q + 1'b1;
          end
        end

        ST_EMIT: begin
          // Everything is frozen until the datapath takes the descriptor.
          if (lyr.lyr_ready) begin
            valid_q <= 1'b0;
            deg_q   <= '0;
            for (int k = 0; k < DMAX; k++) begin
              slot_col_q[k]   <= '0;
              slot_shift_q[k] <= '1;
            end
            if (last_q) begin
              state_q <= ST_CHECK;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= ST_SCAN;
            end
          end
        end

        ST_CHECK: begin
          iter_q <= iter_q + 1'b1;
          if (early_stop_i || (iter_q == IT_W'(MAX_ITER - 1))) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            row_q   <= '0;
            state_q <= ST_SCAN;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign iter_cnt_o    = iter_q;
  assign deg_err_o     = deg_err_q;
  assign lyr.lyr_valid = valid_q;
  assign lyr.lyr_row   = row_q;
  assign lyr.lyr_deg   = deg_q;
  assign lyr.lyr_last  = last_q;

  for (genvar gi = 0; gi < DMAX; gi++) begin : g_slot_pack
    assign lyr.lyr_col[gi*COL_W +: COL_W]       = slot_col_q[gi];
    assign lyr.lyr_shift[gi*SHIFT_W +: SHIFT_W] = slot_shift_q[gi];
  end

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Scoreboard bench for ldpc_layer_scheduler: directed runs push expected descriptors
// and done events into queues; a monitor pops and compares on every handshake/done.
module tb_ldpc_layer_scheduler;
  localparam int Z        = 32;
  localparam int DMAX     = 6;
  localparam int ROW_CNT  = 10;
  localparam int COL_CNT  = 10;
  localparam int MAX_ITER = 8;
  localparam int SHIFT_W  = $clog2(Z) + 1;
  localparam int COL_W    = $clog2(COL_CNT);
  localparam int ROW_W    = $clog2(ROW_CNT);
  localparam int IT_W     = $clog2(MAX_ITER + 1);
  localparam int DEG_W    = $clog2(DMAX + 1);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      cfg_we = 1'b0;
  logic [ROW_W-1:0]          cfg_row = '0;
  logic [COL_W-1:0]          cfg_col = '0;
  logic signed [SHIFT_W-1:0] cfg_shift = '0;
  logic                      start = 1'b0;
  logic                      early_stop;
  logic                      busy;
  logic                      done;
  logic [IT_W-1:0]           iter_cnt;
  logic                      deg_err;

  always #5 clk = ~clk;

  ldpc_layer_scheduler_if #(
    .DMAX(DMAX), .ROW_W(ROW_W), .COL_W(COL_W), .SHIFT_W(SHIFT_W), .DEG_W(DEG_W)
  ) lyr_if ();

  ldpc_layer_scheduler #(
    .Z(Z), .DMAX(DMAX), .ROW_CNT(ROW_CNT), .COL_CNT(COL_CNT), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we_i     (cfg_we),
    .cfg_row_i    (cfg_row),
    .cfg_col_i    (cfg_col),
    .cfg_shift_i  (cfg_shift),
    .start_i      (start),
    .early_stop_i (early_stop),
    .busy_o       (busy),
    .done_o       (done),
    .iter_cnt_o   (iter_cnt),
    .deg_err_o    (deg_err),
    .lyr          (lyr_if.master)
  );

  typedef struct {
    int                      row;
    int                      deg;
    logic [DMAX*COL_W-1:0]   col;
    logic [DMAX*SHIFT_W-1:0] shift;
    bit                      last;
  } desc_t;

  typedef struct {
    int iter;
    bit err;
  } done_t;

  desc_t exp_q[$];
  done_t done_q[$];
  int    model_tab [ROW_CNT][COL_CNT];
  int    checks = 0;
  int    errors = 0;

  // Shared with the ready/early_stop controller.
  int    es_mode = 0;
  bit    stall_req = 0;
  int    stall_left = 0;
  int    lasts_seen = 0;
  bit    chk_pending = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic desc_t model_row(input int r);
    desc_t d;
    d.row   = r;
    d.deg   = 0;
    d.col   = '0;
    d.shift = '1;
    d.last  = (r == ROW_CNT - 1);
    for (int c = 0; c < COL_CNT; c++) begin
      if (model_tab[r][c] >= 0 && d.deg < DMAX) begin
        d.col[d.deg*COL_W +: COL_W]       = COL_W'(c);
        d.shift[d.deg*SHIFT_W +: SHIFT_W] = SHIFT_W'(model_tab[r][c]);
        d.deg++;
      end
    end
    return d;
  endfunction

  task automatic push_iter();
    for (int r = 0; r < ROW_CNT; r++) exp_q.push_back(model_row(r));
  endtask

  task automatic push_done(input int it, input bit err);
    done_t e;
    e.iter = it;
    e.err  = err;
    done_q.push_back(e);
  endtask

  task automatic cfg_write(input int r, input int c, input int s);
    cfg_we    = 1'b1;
    cfg_row   = ROW_W'(r);
    cfg_col   = COL_W'(c);
    cfg_shift = SHIFT_W'(s);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic start_run();
    lasts_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      n++;
      tick();
    end
    if (n >= 3000) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected idle", name, n);
    end
  endtask

  // Scoreboard monitor: pops on every descriptor handshake and every done pulse.
  initial begin
    desc_t e;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst && lyr_if.lyr_valid && lyr_if.lyr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_desc: got row %0d, expected no descriptor", lyr_if.lyr_row);
        end else begin
          e = exp_q.pop_front();
          chk("desc_row", 64'(lyr_if.lyr_row), 64'(e.row));
          chk("desc_deg", 64'(lyr_if.lyr_deg), 64'(e.deg));
          chk("desc_col", 64'(lyr_if.lyr_col), 64'(e.col));
          chk("desc_shift", 64'(lyr_if.lyr_shift), 64'(e.shift));
          chk("desc_last", 64'(lyr_if.lyr_last), 64'(e.last));
          $display("desc row=%0d deg=%0d col=%h shift=%h last=%0d",
                   lyr_if.lyr_row, lyr_if.lyr_deg, lyr_if.lyr_col, lyr_if.lyr_shift, lyr_if.lyr_last);
        end
      end
      if (!rst && done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no done pulse");
        end else begin
          d = done_q.pop_front();
          chk("done_iter", 64'(iter_cnt), 64'(d.iter));
          chk("done_deg_err", 64'(deg_err), 64'(d.err));
          chk("done_busy", 64'(busy), 64'd1);
          $display("done iter_cnt=%0d deg_err=%0d", iter_cnt, deg_err);
        end
      end
    end
  end

  // Ready / early_stop controller, acting just after each rising edge.
  initial begin
    logic [DMAX*COL_W-1:0]   stall_col;
    logic [DMAX*SHIFT_W-1:0] stall_shift;
    stall_col   = {4'd0, 4'd0, 4'd0, 4'd9, 4'd4, 4'd1};
    stall_shift = {6'h3f, 6'h3f, 6'h3f, 6'd31, 6'd17, 6'd0};
    lyr_if.lyr_ready = 1'b1;
    early_stop = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && lyr_if.lyr_valid && lyr_if.lyr_row == ROW_W'(3)) begin
        stall_req  = 0;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        lyr_if.lyr_ready = 1'b0;
        stall_left--;
        chk("stall_valid", 64'(lyr_if.lyr_valid), 64'd1);
        chk("stall_row", 64'(lyr_if.lyr_row), 64'd3);
        chk("stall_deg", 64'(lyr_if.lyr_deg), 64'd3);
        chk("stall_col", 64'(lyr_if.lyr_col), 64'(stall_col));
        chk("stall_shift", 64'(lyr_if.lyr_shift), 64'(stall_shift));
        $display("stall cycle remaining=%0d", stall_left);
      end else begin
        lyr_if.lyr_ready = 1'b1;
      end
      if (chk_pending) begin
        early_stop  = (es_mode == 1) || (es_mode == 2 && lasts_seen >= 2);
        chk_pending = 0;
      end else begin
        early_stop = (es_mode != 0);
      end
      if (lyr_if.lyr_valid && lyr_if.lyr_ready && lyr_if.lyr_last) begin
        lasts_seen++;
        chk_pending = 1;
      end
    end
  end

  initial begin
    int n;
    for (int r = 0; r < ROW_CNT; r++)
      for (int c = 0; c < COL_CNT; c++) model_tab[r][c] = -1;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(lyr_if.lyr_valid), 64'd0);
    chk("rst_iter", 64'(iter_cnt), 64'd0);
    chk("rst_deg_err", 64'(deg_err), 64'd0);
    chk("rst_deg", 64'(lyr_if.lyr_deg), 64'd0);
    chk("rst_col", 64'(lyr_if.lyr_col), 64'd0);
    chk("rst_shift", 64'(lyr_if.lyr_shift), 64'hf_ffff_ffff);
    $display("reset state checked");

    // Run A: empty table, full MAX_ITER iterations of zero-degree layers.
    es_mode = 0;
    for (int i = 0; i < MAX_ITER; i++) push_iter();
    push_done(MAX_ITER, 0);
    start_run();
    n = 0;
    while (busy && n < 3000) begin
      n++;
      tick();
    end
    chk("runA_busy_cycles", 64'(n), 64'(MAX_ITER * (ROW_CNT * (COL_CNT + 1) + 1) + 1));
    chk("runA_iter_hold", 64'(iter_cnt), 64'd8);
    chk("runA_queue_empty", 64'(exp_q.size() + done_q.size()), 64'd0);

    // Program row 3 and an overflowing row 0; out-of-range writes are dropped.
    cfg_write(3, 1, 0);  model_tab[3][1] = 0;
    cfg_write(3, 4, 17); model_tab[3][4] = 17;
    cfg_write(3, 9, 31); model_tab[3][9] = 31;
    for (int c = 0; c < 8; c++) begin
      cfg_write(0, c, 3 * c + 1);
      model_tab[0][c] = 3 * c + 1;
    end
    cfg_write(10, 2, 5);
    cfg_write(2, 10, 5);

    // Run B: write coincident with start lands; early_stop held high -> one iteration.
    es_mode = 1;
    model_tab[7][5] = 12;
    push_iter();
    push_done(1, 1);
    cfg_we = 1'b1; cfg_row = 4'd7; cfg_col = 4'd5; cfg_shift = 6'sd12;
    start_run();
    cfg_we = 1'b0;
    wait_idle("runB");
    repeat (4) tick();
    chk("runB_deg_err_sticky", 64'(deg_err), 64'd1);
    chk("runB_iter_hold", 64'(iter_cnt), 64'd1);

    // Run C: back-pressure on row 3, early_stop low only in the first CHECK,
    // and a write plus start while busy must change nothing.
    es_mode = 2;
    stall_req = 1;
    push_iter();
    push_iter();
    push_done(2, 1);
    start_run();
    chk("runC_deg_err_cleared", 64'(deg_err), 64'd0);
    chk("runC_busy", 64'(busy), 64'd1);
    cfg_we = 1'b1; cfg_row = 4'd5; cfg_col = 4'd2; cfg_shift = 6'sd7;
    start = 1'b1;
    tick();
    cfg_we = 1'b0;
    start = 1'b0;
    wait_idle("runC");
    chk("runC_stall_taken", 64'(stall_req), 64'd0);
    chk("runC_queue_empty", 64'(exp_q.size() + done_q.size()), 64'd0);

    // Run D: reset during SCAN of iteration 2; no done pulse expected.
    es_mode = 0;
    push_iter();
    start_run();
    n = 0;
    while (lasts_seen < 1 && n < 3000) begin
      n++;
      tick();
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL runD_timeout: no last descriptor after %0d cycles", n);
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_valid", 64'(lyr_if.lyr_valid), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    chk("rstmid_deg_err", 64'(deg_err), 64'd0);
    chk("rstmid_iter", 64'(iter_cnt), 64'd0);
    rst = 1'b0;
    for (int r = 0; r < ROW_CNT; r++)
      for (int c = 0; c < COL_CNT; c++) model_tab[r][c] = -1;
    tick();

    // Run E: table must read back null everywhere after the reset.
    es_mode = 1;
    push_iter();
    push_done(1, 0);
    start_run();
    wait_idle("runE");
    repeat (2) tick();
    chk("final_queue_empty", 64'(exp_q.size() + done_q.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
